// File: rtl/nanorv32_test_monitor.sv
`default_nettype none
// ============================================================================
// Module   : nanorv32_test_monitor
// Purpose  : Watches instructions retired by the nanorv32 core and decides the
//            test outcome (pass / fail / unknown / illegal / timeout). It also
//            buffers debug-printf characters in a FIFO and drains them through
//            a valid/ready character stream.
// Ports    : clk, rst                - clock, synchronous active-high reset
//            inst_ret, pc_exe, a0    - retirement strobe, its PC, register x10
//            illegal_instruction     - core flags an illegal instruction
//            done, status            - sticky end-of-test flag and outcome code
//            char_valid/data/eol     - FIFO head (eol = head is line feed)
//            char_ready              - consumer accepts the head character
//            drop_cnt                - characters lost on a full FIFO (saturating)
//            retired_cnt             - retired instructions since reset (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module nanorv32_test_monitor #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter logic [31:0] END_PC         = 32'h0000_0100,
    parameter logic [31:0] PRINTF_PC      = 32'h0000_0088,
    parameter logic [31:0] PASS_CODE      = 32'hCAFF_E000,
    parameter logic [31:0] FAIL_CODE      = 32'hDEAD_D000,
    parameter int unsigned TIMEOUT_W      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 20000000,
    parameter int unsigned FIFO_DEPTH     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_ret,
    input  logic [ADDR_W-1:0] pc_exe,
    input  logic [DATA_W-1:0] a0,
    input  logic              illegal_instruction,
    output logic              done,
    output logic [2:0]        status,
    output logic              char_valid,
    output logic [7:0]        char_data,
    output logic              char_eol,
    input  logic              char_ready,
    output logic [7:0]        drop_cnt,
    output logic [31:0]       retired_cnt
);

    // Address/data constants resized to the port widths (truncate or zero-extend).
    localparam logic [ADDR_W-1:0] c_end_pc    = ADDR_W'(END_PC);
    localparam logic [ADDR_W-1:0] c_printf_pc = ADDR_W'(PRINTF_PC);
    localparam logic [DATA_W-1:0] c_pass_code = DATA_W'(PASS_CODE);
    localparam logic [DATA_W-1:0] c_fail_code = DATA_W'(FAIL_CODE);

    // A zero cycle budget disables the timeout; the "last" value is then unused.
    localparam bit                   c_timeout_en   = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_W-1:0] c_timeout_last = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    localparam int unsigned c_ptr_w = $clog2(FIFO_DEPTH);

    // FSM encoding
    localparam logic [0:0] c_st_run  = 1'b0;
    localparam logic [0:0] c_st_done = 1'b1;

    // Status codes
    localparam logic [2:0] c_stat_running = 3'd0;
    localparam logic [2:0] c_stat_pass    = 3'd1;
    localparam logic [2:0] c_stat_fail    = 3'd2;
    localparam logic [2:0] c_stat_unknown = 3'd3;
    localparam logic [2:0] c_stat_illegal = 3'd4;
    localparam logic [2:0] c_stat_timeout = 3'd5;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [2:0]           r_status;
    logic [2:0]           w_status_nxt;
    logic [TIMEOUT_W-1:0] r_cycle_cnt;
    logic                 w_end_hit;
    logic                 w_timeout_hit;

    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_ptr_w:0]     r_wr_ptr;
    logic [c_ptr_w:0]     r_rd_ptr;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_drop;
    logic [7:0]           r_drop_cnt;
    logic [31:0]          r_retired_cnt;

    // ------------------------------------------------------------------------
    // Test-outcome FSM
    // ------------------------------------------------------------------------
    assign w_end_hit     = inst_ret && (pc_exe == c_end_pc);
    assign w_timeout_hit = c_timeout_en && (r_cycle_cnt == c_timeout_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_run;
            r_status <= c_stat_running;
        end else begin
            r_state  <= w_state_nxt;
            r_status <= w_status_nxt;
        end
    end

    // Priority: illegal (with or without a retirement), then END_PC, then timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        if (r_state == c_st_run) begin
            if (illegal_instruction) begin
                w_state_nxt  = c_st_done;
                w_status_nxt = c_stat_illegal;
            end else if (w_end_hit) begin
                w_state_nxt = c_st_done;
                if (a0 == c_pass_code) begin
                    w_status_nxt = c_stat_pass;
                end else if (a0 == c_fail_code) begin
                    w_status_nxt = c_stat_fail;
                end else begin
                    w_status_nxt = c_stat_unknown;
                end
            end else if (w_timeout_hit) begin
                w_state_nxt  = c_st_done;
                w_status_nxt = c_stat_timeout;
            end
        end
    end

    // Cycle counter only advances while the test is running, so it holds the
    // elapsed test length once DONE is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt <= '0;
        end else if (r_state == c_st_run) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Printf FIFO (pointers carry one extra wrap bit to tell full from empty)
    // ------------------------------------------------------------------------
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                        (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    // An empty FIFO never pops, so push+pop on empty naturally becomes a push.
    assign w_pop      = !w_empty && char_ready;
    assign w_push_req = (r_state == c_st_run) && inst_ret && (pc_exe == c_printf_pc);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: it is only observed through a non-empty head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ptr_w-1:0]] <= a0[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired_cnt <= '0;
        end else if (inst_ret) begin
            r_retired_cnt <= r_retired_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign done        = (r_state == c_st_done);
    assign status      = r_status;
    assign char_valid  = !w_empty;
    // Head is forced to zero while empty so the stream reads 0 after reset.
    assign char_data   = w_empty ? 8'h00 : r_mem[r_rd_ptr[c_ptr_w-1:0]];
    assign char_eol    = !w_empty && (char_data == 8'h0A);
    assign drop_cnt    = r_drop_cnt;
    assign retired_cnt = r_retired_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nanorv32_test_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_nanorv32_test_monitor
// Purpose  : Self-checking bench for nanorv32_test_monitor. A table of single
//            retirement vectors checks the outcome decision, hand sequences
//            cover the printf stream, FIFO full/drop, reset and timeout, and a
//            randomized phase compares every cycle against a queue-based model.
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_nanorv32_test_monitor;

    localparam int unsigned c_depth  = 4;
    localparam logic [31:0] c_end    = 32'h0000_0100;
    localparam logic [31:0] c_printf = 32'h0000_0088;
    localparam logic [31:0] c_pass   = 32'hCAFF_E000;
    localparam logic [31:0] c_fail   = 32'hDEAD_D000;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_ret;
    logic [31:0] pc_exe;
    logic [31:0] a0;
    logic        illegal_instruction;
    logic        done;
    logic [2:0]  status;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_eol;
    logic        char_ready;
    logic [7:0]  drop_cnt;
    logic [31:0] retired_cnt;

    // Signals of the second instance used for the timeout scenario
    logic        to_rst;
    logic        to_inst_ret;
    logic [31:0] to_pc_exe;
    logic [31:0] to_a0;
    logic        to_illegal;
    logic        to_done;
    logic [2:0]  to_status;
    logic        to_char_valid;
    logic [7:0]  to_char_data;
    logic        to_char_eol;
    logic        to_char_ready;
    logic [7:0]  to_drop_cnt;
    logic [31:0] to_retired_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nanorv32_test_monitor #(
        .TIMEOUT_CYCLES (0),
        .FIFO_DEPTH     (c_depth)
    ) u_main (
        .clk                 (clk),
        .rst                 (rst),
        .inst_ret            (inst_ret),
        .pc_exe              (pc_exe),
        .a0                  (a0),
        .illegal_instruction (illegal_instruction),
        .done                (done),
        .status              (status),
        .char_valid          (char_valid),
        .char_data           (char_data),
        .char_eol            (char_eol),
        .char_ready          (char_ready),
        .drop_cnt            (drop_cnt),
        .retired_cnt         (retired_cnt)
    );

    nanorv32_test_monitor #(
        .TIMEOUT_CYCLES (50)
    ) u_to (
        .clk                 (clk),
        .rst                 (to_rst),
        .inst_ret            (to_inst_ret),
        .pc_exe              (to_pc_exe),
        .a0                  (to_a0),
        .illegal_instruction (to_illegal),
        .done                (to_done),
        .status              (to_status),
        .char_valid          (to_char_valid),
        .char_data           (to_char_data),
        .char_eol            (to_char_eol),
        .char_ready          (to_char_ready),
        .drop_cnt            (to_drop_cnt),
        .retired_cnt         (to_retired_cnt)
    );

    // ------------------------------------------------------------------------
    // Reference model: character queue plus the outcome rules
    // ------------------------------------------------------------------------
    logic [7:0]  mq[$];
    bit          m_done;
    int          m_status;
    int          m_drop;
    logic [31:0] m_retired;

    task automatic model_reset();
        mq.delete();
        m_done    = 1'b0;
        m_status  = 0;
        m_drop    = 0;
        m_retired = '0;
    endtask

    // Advances the model by one clock using the inputs currently applied.
    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            if (mq.size() != 0 && char_ready) mq.delete(0);
            if (!m_done && inst_ret && pc_exe == c_printf) begin
                if (mq.size() < c_depth) mq.push_back(a0[7:0]);
                else if (m_drop < 255)   m_drop++;
            end
            if (inst_ret) m_retired++;
            if (!m_done) begin
                if (illegal_instruction) begin
                    m_done = 1'b1; m_status = 4;
                end else if (inst_ret && pc_exe == c_end) begin
                    m_done   = 1'b1;
                    m_status = (a0 == c_pass) ? 1 : (a0 == c_fail) ? 2 : 3;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] head;
        head = (mq.size() != 0) ? mq[0] : 8'h00;
        check({tag, " done"},     32'(done),        32'(m_done));
        check({tag, " status"},   32'(status),      32'(m_status));
        check({tag, " valid"},    32'(char_valid),  32'(mq.size() != 0));
        check({tag, " data"},     32'(char_data),   32'(head));
        check({tag, " eol"},      32'(char_eol),    32'((mq.size() != 0) && head == 8'h0A));
        check({tag, " drop"},     32'(drop_cnt),    32'(m_drop));
        check({tag, " retired"},  32'(retired_cnt), m_retired);
    endtask

    // One clock on the main instance; inputs are driven at the negedge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        inst_ret            = 1'b0;
        illegal_instruction = 1'b0;
        pc_exe              = '0;
        a0                  = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] val);
        inst_ret = 1'b1;
        pc_exe   = pc;
        a0       = val;
        cycle();
        idle();
    endtask

    // ------------------------------------------------------------------------
    // Outcome-decision vectors: one retirement after reset, then status check
    // ------------------------------------------------------------------------
    typedef struct {
        string       name;
        logic        ret;
        logic [31:0] pc;
        logic [31:0] val;
        logic        ill;
        logic        exp_done;
        logic [2:0]  exp_status;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] drain_exp[4];
        int         k;
        bit         seen;
        bit         any_done;

        vecs[0] = '{"pass",         1'b1, c_end,        c_pass,        1'b0, 1'b1, 3'd1};
        vecs[1] = '{"fail",         1'b1, c_end,        c_fail,        1'b0, 1'b1, 3'd2};
        vecs[2] = '{"unknown",      1'b1, c_end,        32'h1234_5678, 1'b0, 1'b1, 3'd3};
        vecs[3] = '{"ill_over_end", 1'b1, c_end,        c_pass,        1'b1, 1'b1, 3'd4};
        vecs[4] = '{"ill_no_ret",   1'b0, 32'h0000_0004, 32'h0,        1'b1, 1'b1, 3'd4};
        vecs[5] = '{"other_pc",     1'b1, 32'h0000_0104, c_pass,       1'b0, 1'b0, 3'd0};
        vecs[6] = '{"printf_pc",    1'b1, c_printf,     c_pass,        1'b0, 1'b0, 3'd0};
        vecs[7] = '{"end_no_ret",   1'b0, c_end,        c_pass,        1'b0, 1'b0, 3'd0};

        rst = 1'b1; char_ready = 1'b0; idle();
        to_rst = 1'b1; to_inst_ret = 1'b0; to_pc_exe = '0; to_a0 = '0;
        to_illegal = 1'b0; to_char_ready = 1'b0;
        model_reset();
        @(negedge clk);
        cycle();

        // Reset values
        check("rst done",    32'(done),        32'd0);
        check("rst status",  32'(status),      32'd0);
        check("rst valid",   32'(char_valid),  32'd0);
        check("rst data",    32'(char_data),   32'd0);
        check("rst eol",     32'(char_eol),    32'd0);
        check("rst drop",    32'(drop_cnt),    32'd0);
        check("rst retired", retired_cnt,      32'd0);
        rst = 1'b0;

        // Table-driven outcome decisions plus stickiness
        char_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do_reset();
            inst_ret            = vecs[i].ret;
            pc_exe              = vecs[i].pc;
            a0                  = vecs[i].val;
            illegal_instruction = vecs[i].ill;
            cycle();
            idle();
            check({vecs[i].name, " done"},   32'(done),   32'(vecs[i].exp_done));
            check({vecs[i].name, " status"}, 32'(status), 32'(vecs[i].exp_status));
            illegal_instruction = 1'b1;
            cycle();
            idle();
            check({vecs[i].name, " sticky status"}, 32'(status),
                  vecs[i].exp_done ? 32'(vecs[i].exp_status) : 32'd4);
        end

        // "Hi\n" through the stream with the consumer always ready
        do_reset();
        char_ready = 1'b1;
        inst_ret = 1'b1; pc_exe = c_printf; a0 = 32'h48; cycle();
        check("hi H valid", 32'(char_valid), 32'd1);
        check("hi H data",  32'(char_data),  32'h48);
        check("hi H eol",   32'(char_eol),   32'd0);
        a0 = 32'h69; cycle();
        check("hi i data",  32'(char_data),  32'h69);
        check("hi i eol",   32'(char_eol),   32'd0);
        a0 = 32'h0A; cycle();
        check("hi LF data", 32'(char_data),  32'h0A);
        check("hi LF eol",  32'(char_eol),   32'd1);
        idle(); cycle();
        check("hi empty",   32'(char_valid), 32'd0);
        check("hi drop",    32'(drop_cnt),   32'd0);
        check("hi retired", retired_cnt,     32'd3);

        // Full FIFO: 6 pushes into depth 4 with the consumer stalled
        do_reset();
        char_ready = 1'b0;
        for (int i = 0; i < 6; i++) retire(c_printf, 32'h41 + 32'(i));
        check("full drop",  32'(drop_cnt),  32'd2);
        check("full head",  32'(char_data), 32'h41);
        cycle();
        check("stall head", 32'(char_data), 32'h41);
        check("stall valid", 32'(char_valid), 32'd1);
        // Push with a simultaneous pop while full is accepted
        char_ready = 1'b1;
        retire(c_printf, 32'h47);
        check("pushpop drop", 32'(drop_cnt), 32'd2);
        drain_exp[0] = 8'h42; drain_exp[1] = 8'h43;
        drain_exp[2] = 8'h44; drain_exp[3] = 8'h47;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d valid", i), 32'(char_valid), 32'd1);
            check($sformatf("drain%0d data", i),  32'(char_data),  32'(drain_exp[i]));
            cycle();
        end
        check("drain empty", 32'(char_valid), 32'd0);

        // Reset mid-operation with queued characters and a pass status
        do_reset();
        char_ready = 1'b0;
        retire(c_printf, 32'h58);
        retire(c_printf, 32'h59);
        retire(c_printf, 32'h5A);
        retire(c_end, c_pass);
        check("pre-rst status", 32'(status),     32'd1);
        check("pre-rst valid",  32'(char_valid), 32'd1);
        rst = 1'b1; cycle(); rst = 1'b0;
        check("mid-rst done",    32'(done),        32'd0);
        check("mid-rst status",  32'(status),      32'd0);
        check("mid-rst valid",   32'(char_valid),  32'd0);
        check("mid-rst data",    32'(char_data),   32'd0);
        check("mid-rst eol",     32'(char_eol),    32'd0);
        check("mid-rst drop",    32'(drop_cnt),    32'd0);
        check("mid-rst retired", retired_cnt,      32'd0);
        char_ready = 1'b1;
        retire(c_printf, 32'h21);
        check("post-rst valid", 32'(char_valid), 32'd1);
        check("post-rst data",  32'(char_data),  32'h21);

        // Timeout disabled: 1000 idle cycles never finish the test
        do_reset();
        any_done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            any_done |= done;
        end
        check("no-timeout done", 32'(any_done), 32'd0);

        // Timeout of 50 cycles on the second instance
        to_rst = 1'b1;
        @(posedge clk); @(negedge clk);
        to_rst = 1'b0;
        seen = 1'b0;
        k = 0;
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(posedge clk); @(negedge clk);
            if (to_done) begin
                seen = 1'b1;
                k    = i;
            end
        end
        check("timeout seen",   32'(seen),      32'd1);
        check("timeout cycle",  32'(k),         32'd50);
        check("timeout status", 32'(to_status), 32'd5);
        check("timeout cnt",    u_to.r_cycle_cnt, 32'd50);
        repeat (20) begin @(posedge clk); @(negedge clk); end
        check("timeout frozen cnt", u_to.r_cycle_cnt, 32'd50);
        check("timeout sticky",     32'(to_done),     32'd1);

        // Randomized episodes against the reference model
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            check_model($sformatf("rnd%0d reset", ep));
            for (int c = 0; c < 300; c++) begin
                int sel;
                inst_ret = ($urandom_range(0, 9) < 6);
                sel = $urandom_range(0, 99);
                if (sel < 45)      pc_exe = c_printf;
                else if (sel < 47) pc_exe = c_end;
                else               pc_exe = $urandom_range(0, 511) & 32'hFFFF_FFFC;
                sel = $urandom_range(0, 3);
                a0 = (sel == 0) ? c_pass : (sel == 1) ? c_fail : $urandom;
                illegal_instruction = ($urandom_range(0, 299) == 0);
                char_ready = ($urandom_range(0, 1) == 1);
                cycle();
                check_model($sformatf("rnd%0d c%0d", ep, c));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
